// File: rtl/cat24c02_i2c_ctrl.sv
// cat24c02_i2c_ctrl: single-byte write / random-read I2C master for a CAT24C02 EEPROM.
// Each SCL bit is four quarters of CLK_DIV clocks; SCL/SDA are open-drain enables.
// Optional feature: define CAT24C02_ACK_POLL_EN to ACK-poll the device after a write.
`timescale 1ns/1ps
module cat24c02_i2c_ctrl #(
    parameter int unsigned CLK_DIV  = 25,
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned POLL_MAX = 255
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ,
    input  logic       WR,
    input  logic [7:0] ADDR,
    input  logic [7:0] WDATA,
    output logic [7:0] RDATA,
    output logic       BUSY,
    output logic       DONE,
    output logic       NACK,
    output logic       SCL_OE,
    output logic       SDA_OE,
    input  logic       SDA_I
);

`ifdef CAT24C02_ACK_POLL_EN
    localparam bit PollEn = 1'b1;
`else
    localparam bit PollEn = 1'b0;
`endif

    typedef enum logic [3:0] {
        StIdle, StStart, StDevW, StAckA, StWord, StAckB, StWbyte, StAckC,
        StRstart, StDevR, StAckD, StRbyte, StMnack, StStop, StPollWait
    } state_e;

    state_e      state_q;
    logic [9:0]  div_q;
    logic [1:0]  qtr_q;
    logic [3:0]  bit_q;
    logic [7:0]  sh_q;
    logic        smp_q;
    logic        wr_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        busy_q;
    logic        done_q;
    logic        nack_q;
    logic        scl_oe_q;
    logic        sda_oe_q;
    logic        polling_q;
    logic        poll_ok_q;
    logic [15:0] poll_cnt_q;

    logic div_end;
    logic smp_pt;
    logic bit_end;
    logic scl_low_phase;
    logic scl_drv;
    logic sda_drv;

    assign div_end       = (div_q == 10'(CLK_DIV - 1));
    assign smp_pt        = div_end && (qtr_q == 2'd2);
    assign bit_end       = div_end && (qtr_q == 2'd3);
    assign scl_low_phase = (qtr_q == 2'd0) || (qtr_q == 2'd3);

    // Bus levels for the current state/quarter; registered below so the pins are glitch-free.
    always_comb begin
        scl_drv = 1'b0;
        sda_drv = 1'b0;
        unique case (state_q)
            StIdle, StPollWait: ;
            // Bus is idle on entry, so SCL stays released until SDA has fallen.
            StStart: begin
                scl_drv = (qtr_q == 2'd3);
                sda_drv = qtr_q[1];
            end
            StRstart: begin
                scl_drv = scl_low_phase;
                sda_drv = qtr_q[1];
            end
            StDevW, StWord, StWbyte, StDevR: begin
                scl_drv = scl_low_phase;
                sda_drv = ~sh_q[7];
            end
            StAckA, StAckB, StAckC, StAckD, StRbyte, StMnack: begin
                scl_drv = scl_low_phase;
            end
            // Bit 0 is the STOP condition, bit 1 is a fully released idle bit.
            StStop: begin
                if (bit_q == 4'd0) begin
                    scl_drv = (qtr_q == 2'd0);
                    sda_drv = ~qtr_q[1];
                end
            end
            default: ;
        endcase
    end

    // Transaction FSM, bit timing counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            div_q      <= 10'd0;
            qtr_q      <= 2'd0;
            bit_q      <= 4'd0;
            sh_q       <= 8'h00;
            smp_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            polling_q  <= 1'b0;
            poll_ok_q  <= 1'b0;
            poll_cnt_q <= 16'd0;
        end else begin
            done_q   <= 1'b0;
            scl_oe_q <= scl_drv;
            sda_oe_q <= sda_drv;
            if (state_q == StIdle) begin
                div_q <= 10'd0;
                qtr_q <= 2'd0;
                bit_q <= 4'd0;
                if (REQ) begin
                    wr_q       <= WR;
                    addr_q     <= ADDR;
                    wdata_q    <= WDATA;
                    busy_q     <= 1'b1;
                    nack_q     <= 1'b0;
                    polling_q  <= 1'b0;
                    poll_ok_q  <= 1'b0;
                    poll_cnt_q <= 16'd0;
                    state_q    <= StStart;
                end
            end else begin
                if (div_end) begin
                    div_q <= 10'd0;
                    qtr_q <= qtr_q + 2'd1;
                end else begin
                    div_q <= div_q + 10'd1;
                end
                if (smp_pt) begin
                    smp_q <= SDA_I;
                end
                if (bit_end) begin
                    unique case (state_q)
                        StStart: begin
                            sh_q    <= {DEV_ADDR, 1'b0};
                            bit_q   <= 4'd0;
                            state_q <= StDevW;
                        end
                        StDevW, StWord, StWbyte, StDevR: begin
                            sh_q  <= {sh_q[6:0], 1'b0};
                            bit_q <= bit_q + 4'd1;
                            if (bit_q == 4'd7) begin
                                bit_q <= 4'd0;
                                case (state_q)
                                    StDevW:  state_q <= StAckA;
                                    StWord:  state_q <= StAckB;
                                    StWbyte: state_q <= StAckC;
                                    default: state_q <= StAckD;
                                endcase
                            end
                        end
                        StAckA: begin
                            if (polling_q) begin
                                // A poll only probes the device; the outcome is judged after STOP.
                                poll_ok_q <= ~smp_q;
                                state_q   <= StStop;
                            end else if (smp_q) begin
                                nack_q  <= 1'b1;
                                state_q <= StStop;
                            end else begin
                                sh_q    <= addr_q;
                                state_q <= StWord;
                            end
                        end
                        StAckB: begin
                            if (smp_q) begin
                                nack_q  <= 1'b1;
                                state_q <= StStop;
                            end else if (wr_q) begin
                                sh_q    <= wdata_q;
                                state_q <= StWbyte;
                            end else begin
                                state_q <= StRstart;
                            end
                        end
                        StAckC: begin
                            if (smp_q) begin
                                nack_q <= 1'b1;
                            end
                            state_q <= StStop;
                        end
                        StRstart: begin
                            sh_q    <= {DEV_ADDR, 1'b1};
                            bit_q   <= 4'd0;
                            state_q <= StDevR;
                        end
                        StAckD: begin
                            if (smp_q) begin
                                nack_q  <= 1'b1;
                                state_q <= StStop;
                            end else begin
                                bit_q   <= 4'd0;
                                state_q <= StRbyte;
                            end
                        end
                        StRbyte: begin
                            sh_q  <= {sh_q[6:0], smp_q};
                            bit_q <= bit_q + 4'd1;
                            if (bit_q == 4'd7) begin
                                bit_q   <= 4'd0;
                                state_q <= StMnack;
                            end
                        end
                        // Reaching here means every ACK was seen, so the read is good.
                        StMnack: begin
                            rdata_q <= sh_q;
                            state_q <= StStop;
                        end
                        StStop: begin
                            if (bit_q == 4'd0) begin
                                bit_q <= 4'd1;
                            end else begin
                                bit_q <= 4'd0;
                                if (PollEn && wr_q && !nack_q && !polling_q) begin
                                    polling_q  <= 1'b1;
                                    poll_cnt_q <= 16'd0;
                                    state_q    <= StPollWait;
                                end else if (polling_q && !poll_ok_q &&
                                             (32'(poll_cnt_q) + 32'd1 < POLL_MAX)) begin
                                    poll_cnt_q <= poll_cnt_q + 16'd1;
                                    state_q    <= StPollWait;
                                end else begin
                                    if (polling_q && !poll_ok_q) begin
                                        nack_q <= 1'b1;
                                    end
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= StIdle;
                                end
                            end
                        end
                        StPollWait: begin
                            state_q <= StStart;
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

    assign RDATA  = rdata_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign NACK   = nack_q;
    assign SCL_OE = scl_oe_q;
    assign SDA_OE = sda_oe_q;

endmodule
